// File: rtl/sid_rec_pkg.sv
// -----------------------------------------------------------------------------
// sid_rec_pkg
// Shared definitions for the SID record stream: the record field widths, the
// DELAY command address (also decoded by the ROM-driven player) and the record
// packing helper.  A record is {addr[4:0], data[7:0]}.
// -----------------------------------------------------------------------------
package sid_rec_pkg;

  localparam int REC_ADDR_W = 5;
  localparam int REC_DATA_W = 8;
  localparam int REC_W      = REC_ADDR_W + REC_DATA_W;

  // Address value reserved for "wait N+1 SID cycles" records.
  localparam logic [REC_ADDR_W-1:0] DELAY_CMD = 5'h1f;

  typedef struct packed {
    logic [REC_ADDR_W-1:0] addr;
    logic [REC_DATA_W-1:0] data;
  } rec_t;

  function automatic logic [REC_W-1:0] pack_rec(input logic [REC_ADDR_W-1:0] a,
                                                input logic [REC_DATA_W-1:0] d);
    return {a, d};
  endfunction

endpackage

// File: rtl/sid_rec_fifo.sv
// -----------------------------------------------------------------------------
// sid_rec_fifo
// Record FIFO, REC_W bits wide and FIFO_DEPTH deep.  Accepts up to two records
// per clock (push0 is stored ahead of push1) and releases one per clock.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
//
// Ports:
//   clk, reset     clock, asynchronous active-high reset (pointers only)
//   push0, din0    first record written this clock
//   push1, din1    second record written this clock (after din0)
//   pop            remove the head record (ignored when empty)
//   dout           head record (combinational read of the head slot)
//   empty          FIFO holds no records
//   free           number of free slots before this clock's push/pop
// -----------------------------------------------------------------------------
module sid_rec_fifo
  import sid_rec_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  localparam int AW = $clog2(FIFO_DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push0,
  input  logic             push1,
  input  logic [REC_W-1:0] din0,
  input  logic [REC_W-1:0] din1,
  input  logic             pop,
  output logic [REC_W-1:0] dout,
  output logic             empty,
  output logic [AW:0]      free
);

  logic [REC_W-1:0] mem [FIFO_DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [AW:0]      used;
  logic [AW:0]      n_push;
  logic [AW-1:0]    wr_idx;
  logic [AW-1:0]    wr_idx1;

  assign used    = wr_ptr - rd_ptr;
  assign empty   = (used == '0);
  assign free    = (AW+1)'(FIFO_DEPTH) - used;
  assign n_push  = (AW+1)'(push0) + (AW+1)'(push1);
  assign wr_idx  = wr_ptr[AW-1:0];
  assign wr_idx1 = wr_idx + AW'(1);
  assign dout    = mem[rd_ptr[AW-1:0]];

  // Storage is data-only and carries no reset; validity is defined by the
  // pointers.  A lone push1 still lands in the first free slot.
  always_ff @(posedge clk) begin
    if (push0 || push1) begin
      mem[wr_idx] <= push0 ? din0 : din1;
    end
    if (push0 && push1) begin
      mem[wr_idx1] <= din1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      wr_ptr <= wr_ptr + n_push;
      if (pop && !empty) begin
        rd_ptr <= rd_ptr + (AW+1)'(1);
      end
    end
  end

endmodule

// File: rtl/sid_write_recorder.sv
// -----------------------------------------------------------------------------
// sid_write_recorder
// Snoops the SID write bus and encodes it into the player's record stream.
// Every enabled SID cycle (ce_1m=1, enable=1) is a tick.  A write tick becomes
// one {addr,data} record; runs of idle ticks are folded into DELAY records
// (addr=DELAY_CMD, data=N covering N+1 idle cycles).  Records are buffered in
// a small FIFO and drained through a valid/ready port.
//
// Ports:
//   clk        system clock (12 MHz)
//   reset      asynchronous active-high reset
//   ce_1m      one-clk strobe per SID cycle
//   enable     recording enable
//   we         SID write enable (sampled when ce_1m=1)
//   addr,data  SID register address / data
//   rec_valid  FIFO head valid
//   rec_ready  consumer accepts head record
//   rec_addr   head record address field (0 when empty)
//   rec_data   head record data field (0 when empty)
//   overflow   sticky: records were dropped because the FIFO lacked room
//   bad_addr   sticky: a write to DELAY_CMD was observed
//   rec_count  records accepted into the FIFO, saturating
// -----------------------------------------------------------------------------
module sid_write_recorder
  import sid_rec_pkg::*;
#(
  parameter int FIFO_DEPTH  = 8,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   ce_1m,
  input  logic                   enable,
  input  logic                   we,
  input  logic [4:0]             addr,
  input  logic [7:0]             data,
  output logic                   rec_valid,
  input  logic                   rec_ready,
  output logic [4:0]             rec_addr,
  output logic [7:0]             rec_data,
  output logic                   overflow,
  output logic                   bad_addr,
  output logic [COUNT_WIDTH-1:0] rec_count
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic             enable_q;
  logic [7:0]       idle_c;
  logic [7:0]       idle_c_nxt;
  logic [7:0]       dly_n;
  logic             tick;
  logic             fall;
  logic             wr_tick;
  logic             bad_tick;
  logic [1:0]       n_rec;
  logic [REC_W-1:0] rec0;
  logic [REC_W-1:0] rec1;
  logic [AW:0]      free;
  logic [AW+1:0]    avail;
  logic             fits;
  logic             push0;
  logic             push1;
  logic             pop;
  logic             empty;
  logic [REC_W-1:0] head;
  rec_t             head_r;

  function automatic logic [COUNT_WIDTH-1:0] sat_add(input logic [COUNT_WIDTH-1:0] a,
                                                     input logic [1:0] n);
    logic [COUNT_WIDTH:0] sum;
    sum = {1'b0, a} + (COUNT_WIDTH+1)'(n);
    return sum[COUNT_WIDTH] ? '1 : sum[COUNT_WIDTH-1:0];
  endfunction

  assign tick     = ce_1m & enable;
  assign fall     = enable_q & ~enable;
  assign bad_tick = tick & we & (addr == DELAY_CMD);
  // A write to the DELAY address cannot be represented, so that cycle
  // counts as idle.
  assign wr_tick  = tick & we & (addr != DELAY_CMD);
  assign dly_n    = idle_c - 8'd1;

  // Record generation and idle-run bookkeeping.  The write record always
  // follows the DELAY that closes the preceding idle run.
  always_comb begin
    idle_c_nxt = idle_c;
    n_rec      = 2'd0;
    rec0       = '0;
    rec1       = '0;
    if (fall) begin
      if (idle_c != 8'd0) begin
        rec0  = pack_rec(DELAY_CMD, dly_n);
        n_rec = 2'd1;
      end
      idle_c_nxt = 8'd0;
    end else if (!enable) begin
      idle_c_nxt = 8'd0;
    end else if (wr_tick) begin
      if (idle_c != 8'd0) begin
        rec0  = pack_rec(DELAY_CMD, dly_n);
        rec1  = pack_rec(addr, data);
        n_rec = 2'd2;
      end else begin
        rec0  = pack_rec(addr, data);
        n_rec = 2'd1;
      end
      idle_c_nxt = 8'd0;
    end else if (tick) begin
      if (idle_c == 8'hff) begin
        rec0       = pack_rec(DELAY_CMD, 8'hff);
        n_rec      = 2'd1;
        idle_c_nxt = 8'd0;
      end else begin
        idle_c_nxt = idle_c + 8'd1;
      end
    end
  end

  // A pop in the same clock frees its slot for this clock's push.  Pushes
  // are all-or-nothing so a DELAY is never stored without its write.
  assign pop   = rec_valid & rec_ready;
  assign avail = (AW+2)'(free) + (AW+2)'(pop);
  assign fits  = ((AW+2)'(n_rec) <= avail);
  assign push0 = (n_rec != 2'd0) & fits;
  assign push1 = (n_rec == 2'd2) & fits;

  sid_rec_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push0 (push0),
    .push1 (push1),
    .din0  (rec0),
    .din1  (rec1),
    .pop   (pop),
    .dout  (head),
    .empty (empty),
    .free  (free)
  );

  // Head fields are forced to zero when empty so the unreset storage never
  // shows on the port.
  assign head_r    = rec_t'(head);
  assign rec_valid = ~empty;
  assign rec_addr  = rec_valid ? head_r.addr : '0;
  assign rec_data  = rec_valid ? head_r.data : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      enable_q  <= 1'b0;
      idle_c    <= 8'd0;
      overflow  <= 1'b0;
      bad_addr  <= 1'b0;
      rec_count <= '0;
    end else begin
      enable_q <= enable;
      idle_c   <= idle_c_nxt;
      if ((n_rec != 2'd0) && !fits) begin
        overflow <= 1'b1;
      end
      if (bad_tick) begin
        bad_addr <= 1'b1;
      end
      if (push0) begin
        rec_count <= sat_add(rec_count, n_rec);
      end
    end
  end

endmodule

// File: tb/tb_sid_write_recorder.sv
module tb_sid_write_recorder;

  localparam int DEPTH = 8;
  localparam int CW    = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          ce_1m;
  logic          enable;
  logic          we;
  logic [4:0]    addr;
  logic [7:0]    data;
  logic          rec_valid;
  logic          rec_ready;
  logic [4:0]    rec_addr;
  logic [7:0]    rec_data;
  logic          overflow;
  logic          bad_addr;
  logic [CW-1:0] rec_count;

  int total = 0;
  int bad   = 0;

  // Reference model: expected FIFO contents as a queue, pending idle-tick
  // count, sticky flags and accepted-record count.
  logic [12:0] mq[$];
  logic [12:0] got[$];
  logic [12:0] ex[$];
  int          mc;
  bit          m_en_q;
  bit          m_ovf;
  bit          m_bad;
  int          m_cnt;

  always #5 clk = ~clk;

  sid_write_recorder #(
    .FIFO_DEPTH  (DEPTH),
    .COUNT_WIDTH (CW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .ce_1m     (ce_1m),
    .enable    (enable),
    .we        (we),
    .addr      (addr),
    .data      (data),
    .rec_valid (rec_valid),
    .rec_ready (rec_ready),
    .rec_addr  (rec_addr),
    .rec_data  (rec_data),
    .overflow  (overflow),
    .bad_addr  (bad_addr),
    .rec_count (rec_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_state();
    chk("rec_valid", 32'(rec_valid), 32'(mq.size() != 0));
    if (mq.size() != 0) begin
      chk("rec_addr", 32'(rec_addr), 32'(mq[0][12:8]));
      chk("rec_data", 32'(rec_data), 32'(mq[0][7:0]));
    end
    chk("overflow", 32'(overflow), 32'(m_ovf));
    chk("bad_addr", 32'(bad_addr), 32'(m_bad));
    chk("rec_count", 32'(rec_count), 32'(m_cnt));
  endtask

  // One clock of stimulus: drive inputs, advance the model, then check after
  // the edge.
  task automatic step(input bit ce, input bit en, input bit w,
                      input logic [4:0] a, input logic [7:0] d, input bit rdy);
    logic [12:0] recs[$];
    bit          pop;
    ce_1m     = ce;
    enable    = en;
    we        = w;
    addr      = a;
    data      = d;
    rec_ready = rdy;
    if (rec_valid && rdy) got.push_back({rec_addr, rec_data});
    pop = (mq.size() != 0) && rdy;
    if (m_en_q && !en) begin
      if (mc > 0) recs.push_back({5'h1f, 8'(mc - 1)});
      mc = 0;
    end else if (en && ce) begin
      if (w && a != 5'h1f) begin
        if (mc > 0) recs.push_back({5'h1f, 8'(mc - 1)});
        recs.push_back({a, d});
        mc = 0;
      end else begin
        if (w) m_bad = 1'b1;
        mc++;
        if (mc == 256) begin
          recs.push_back({5'h1f, 8'hff});
          mc = 0;
        end
      end
    end
    m_en_q = en;
    if (pop) void'(mq.pop_front());
    if (recs.size() > 0) begin
      if (mq.size() + recs.size() <= DEPTH) begin
        foreach (recs[k]) mq.push_back(recs[k]);
        m_cnt += recs.size();
        if (m_cnt > (1 << CW) - 1) m_cnt = (1 << CW) - 1;
      end else begin
        m_ovf = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    check_state();
  endtask

  task automatic drain(input int n, input bit en);
    repeat (n) step(1'b0, en, 1'b0, 5'h00, 8'h00, 1'b1);
  endtask

  task automatic do_reset();
    ce_1m  = 1'b0;
    enable = 1'b0;
    we     = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk("rst_async_valid", 32'(rec_valid), 32'd0);
    chk("rst_async_addr", 32'(rec_addr), 32'd0);
    chk("rst_async_data", 32'(rec_data), 32'd0);
    chk("rst_async_ovf", 32'(overflow), 32'd0);
    chk("rst_async_bad", 32'(bad_addr), 32'd0);
    chk("rst_async_cnt", 32'(rec_count), 32'd0);
    mq.delete();
    mc     = 0;
    m_en_q = 1'b0;
    m_ovf  = 1'b0;
    m_bad  = 1'b0;
    m_cnt  = 0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    chk("rst_clk_valid", 32'(rec_valid), 32'd0);
  endtask

  task automatic chk_got(input string tag);
    chk({tag, "_len"}, 32'(got.size()), 32'(ex.size()));
    foreach (ex[k]) begin
      if (k < got.size()) chk({tag, "_rec"}, 32'(got[k]), 32'(ex[k]));
    end
  endtask

  initial begin
    bit en_r;
    reset     = 1'b1;
    ce_1m     = 1'b0;
    enable    = 1'b0;
    we        = 1'b0;
    addr      = '0;
    data      = '0;
    rec_ready = 1'b0;
    @(posedge clk);
    #1;
    do_reset();

    // Three back-to-back writes.
    got.delete();
    step(1, 1, 1, 5'h00, 8'h11, 1);
    step(1, 1, 1, 5'h01, 8'h22, 1);
    step(1, 1, 1, 5'h04, 8'h41, 1);
    drain(3, 1);
    ex = '{{5'h00, 8'h11}, {5'h01, 8'h22}, {5'h04, 8'h41}};
    chk_got("three_writes");
    chk("three_writes_cnt", 32'(rec_count), 32'd3);

    // Write, 5 idle ticks, write.
    got.delete();
    step(1, 1, 1, 5'h18, 8'h0f, 1);
    repeat (5) step(1, 1, 0, 5'h00, 8'h00, 1);
    step(1, 1, 1, 5'h04, 8'h40, 1);
    drain(4, 1);
    ex = '{{5'h18, 8'h0f}, {5'h1f, 8'h04}, {5'h04, 8'h40}};
    chk_got("short_gap");

    // 600 idle ticks split into 256 + 256 + 88.
    got.delete();
    repeat (600) step(1, 1, 0, 5'h00, 8'h00, 1);
    step(1, 1, 1, 5'h00, 8'h01, 1);
    drain(5, 1);
    ex = '{{5'h1f, 8'hff}, {5'h1f, 8'hff}, {5'h1f, 8'h57}, {5'h00, 8'h01}};
    chk_got("long_gap");

    // Overflow with the consumer stalled.
    do_reset();
    got.delete();
    for (int i = 0; i < 10; i++) step(1, 1, 1, 5'(i), 8'hA0 + 8'(i), 0);
    chk("ovf_flag", 32'(overflow), 32'd1);
    chk("ovf_cnt", 32'(rec_count), 32'd8);
    drain(10, 1);
    ex.delete();
    for (int i = 0; i < 8; i++) ex.push_back({5'(i), 8'hA0 + 8'(i)});
    chk_got("ovf_drain");
    chk("ovf_sticky", 32'(overflow), 32'd1);

    // Enable falling edge flushes the idle run; disabled strobes ignored.
    got.delete();
    repeat (3) step(1, 1, 0, 5'h00, 8'h00, 1);
    step(1, 0, 0, 5'h00, 8'h00, 1);
    repeat (10) step(1, 0, 1, 5'h03, 8'h99, 1);
    drain(3, 0);
    ex = '{{5'h1f, 8'h02}};
    chk_got("enable_fall");
    step(1, 1, 1, 5'h1f, 8'h55, 1);
    drain(3, 1);
    chk("bad_addr_set", 32'(bad_addr), 32'd1);
    chk_got("bad_addr_norec");

    // Reset with records queued and an idle run pending.
    step(1, 1, 1, 5'h02, 8'h33, 1);
    drain(3, 1);
    for (int i = 0; i < 4; i++) step(1, 1, 1, 5'h08 + 5'(i), 8'h10 + 8'(i), 0);
    repeat (7) step(1, 1, 0, 5'h00, 8'h00, 0);
    chk("pre_reset_valid", 32'(rec_valid), 32'd1);
    do_reset();
    chk("post_reset_ovf", 32'(overflow), 32'd0);
    chk("post_reset_cnt", 32'(rec_count), 32'd0);
    got.delete();
    step(1, 1, 1, 5'h03, 8'h44, 1);
    drain(3, 1);
    ex = '{{5'h03, 8'h44}};
    chk_got("after_reset");
    chk("after_reset_cnt", 32'(rec_count), 32'd1);

    // Randomized traffic against the model.
    en_r = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 49) == 0) en_r = ~en_r;
      step(1'($urandom_range(0, 1)), en_r, ($urandom_range(0, 2) == 0),
           5'($urandom), 8'($urandom), ($urandom_range(0, 3) != 0));
    end
    drain(20, en_r);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
